// File: rtl/huge_ball_if.sv
// huge_ball_if: signal bundle between the scan/game logic and one huge-ball controller.
// The freeze signal exists only when HUGE_BALL_FREEZE_EN is defined.
interface huge_ball_if;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        launch;
  logic [10:0] initX;
  logic        initDirLeft;
  logic        hit;
`ifdef HUGE_BALL_FREEZE_EN
  logic        freeze;
`endif
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic        active;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        popped;
  modport master (
`ifdef HUGE_BALL_FREEZE_EN
    output freeze,
`endif
    output startOfFrame, pixelX, pixelY, launch, initX, initDirLeft, hit,
    input  offsetX, offsetY, InsideRectangle, active, topLeftX, topLeftY, popped
  );
  modport slave (
`ifdef HUGE_BALL_FREEZE_EN
    input  freeze,
`endif
    input  startOfFrame, pixelX, pixelY, launch, initX, initDirLeft, hit,
    output offsetX, offsetY, InsideRectangle, active, topLeftX, topLeftY, popped
  );
endinterface

// File: rtl/huge_ball_controller.sv
// huge_ball_controller: position, motion, lifetime and pixel bracket of one huge ball.
// Optional HUGE_BALL_FREEZE_EN adds a freeze input that stalls motion and the pop timer.
module huge_ball_controller #(
  parameter int OBJECT_SIZE = 52,
  parameter int LEFT_X      = 0,
  parameter int RIGHT_X     = 640,
  parameter int TOP_Y       = 0,
  parameter int FLOOR_Y     = 440,
  parameter int FRAC_BITS   = 6,
  parameter int GRAVITY     = 4,
  parameter int BOUNCE_VY   = 448,
  parameter int HORIZ_VX    = 128,
  parameter int INIT_Y      = 40,
  parameter int POP_FRAMES  = 16
) (
  input  logic      clk,
  input  logic      reset,
  huge_ball_if.slave bus
);
  localparam int W  = 11 + FRAC_BITS + 1;
  localparam int CW = $clog2(POP_FRAMES) + 1;
  localparam logic signed [W-1:0] X_MIN  = W'(LEFT_X << FRAC_BITS);
  localparam logic signed [W-1:0] X_MAX  = W'((RIGHT_X - OBJECT_SIZE) << FRAC_BITS);
  localparam logic signed [W-1:0] Y_MIN  = W'(TOP_Y << FRAC_BITS);
  localparam logic signed [W-1:0] Y_MAX  = W'((FLOOR_Y - OBJECT_SIZE) << FRAC_BITS);
  localparam logic signed [W-1:0] Y_INIT = W'(INIT_Y << FRAC_BITS);
  localparam logic signed [W-1:0] G      = W'(GRAVITY);
  localparam logic signed [W-1:0] VY_UP  = W'(-BOUNCE_VY);
  localparam logic signed [W-1:0] VX_POS = W'(HORIZ_VX);
  localparam logic signed [W-1:0] VX_NEG = W'(-HORIZ_VX);
  localparam logic [11:0]         SZ     = 12'(OBJECT_SIZE);
  localparam logic [CW-1:0]       CNT_LAST = CW'(POP_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, MOVING, POPPING} state_t;
  state_t              r_state;
  logic signed [W-1:0] r_x, r_y, r_vx, r_vy;
  logic [CW-1:0]       r_cnt;
  logic                r_active, r_popped, r_inside;
  logic [10:0]         r_ox, r_oy;
  logic                w_sof, w_in;
  logic [10:0]         w_tlx, w_tly;
  logic signed [W-1:0] w_vy_g, w_y_s, w_x_s, w_y_n, w_x_n, w_vy_n, w_vx_n;
`ifdef HUGE_BALL_FREEZE_EN
  assign w_sof = bus.startOfFrame & ~bus.freeze;
`else
  assign w_sof = bus.startOfFrame;
`endif
  assign w_tlx = r_x[W-2:FRAC_BITS];
  assign w_tly = r_y[W-2:FRAC_BITS];
  // Gravity feeds the position update in the same frame; bounds act on the updated values.
  always_comb begin
    w_vy_g = r_vy + G;
    w_y_s  = r_y + w_vy_g;
    w_x_s  = r_x + r_vx;
    w_y_n  = w_y_s > Y_MAX ? Y_MAX : w_y_s < Y_MIN ? Y_MIN : w_y_s;
    w_vy_n = w_y_s > Y_MAX ? VY_UP : w_y_s < Y_MIN ? (w_vy_g < 0 ? -w_vy_g : w_vy_g) : w_vy_g;
    w_x_n  = w_x_s > X_MAX ? X_MAX : w_x_s < X_MIN ? X_MIN : w_x_s;
    w_vx_n = w_x_s > X_MAX ? VX_NEG : w_x_s < X_MIN ? VX_POS : r_vx;
    w_in   = r_active
      && {1'b0, bus.pixelX} >= {1'b0, w_tlx} && {1'b0, bus.pixelX} < {1'b0, w_tlx} + SZ
      && {1'b0, bus.pixelY} >= {1'b0, w_tly} && {1'b0, bus.pixelY} < {1'b0, w_tly} + SZ;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_vx     <= '0;
      r_vy     <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_popped <= 1'b0;
      r_inside <= 1'b0;
      r_ox     <= '0;
      r_oy     <= '0;
    end else begin
      r_popped <= 1'b0;
      r_inside <= w_in;
      r_ox     <= w_in ? bus.pixelX - w_tlx : '0;
      r_oy     <= w_in ? bus.pixelY - w_tly : '0;
      case (r_state)
        IDLE: if (bus.launch) begin
          r_state  <= MOVING;
          r_active <= 1'b1;
          r_x      <= W'(bus.initX) << FRAC_BITS;
          r_y      <= Y_INIT;
          r_vx     <= bus.initDirLeft ? VX_NEG : VX_POS;
          r_vy     <= '0;
        end
        MOVING: if (bus.hit) begin
          r_state  <= POPPING;
          r_popped <= 1'b1;
          r_cnt    <= '0;
        end else if (w_sof) begin
          r_x  <= w_x_n;
          r_y  <= w_y_n;
          r_vx <= w_vx_n;
          r_vy <= w_vy_n;
        end
        POPPING: if (w_sof) begin
          r_cnt    <= r_cnt + 1'b1;
          r_state  <= r_cnt == CNT_LAST ? IDLE : POPPING;
          r_active <= r_cnt != CNT_LAST;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.offsetX         = r_ox;
  assign bus.offsetY         = r_oy;
  assign bus.InsideRectangle = r_inside;
  assign bus.active          = r_active;
  assign bus.topLeftX        = w_tlx;
  assign bus.topLeftY        = w_tly;
  assign bus.popped          = r_popped;
endmodule

// File: tb/tb_huge_ball_controller.sv
// tb_huge_ball_controller: cycle-stepped reference model feeding an expected-value queue for the huge ball.
module tb_huge_ball_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  huge_ball_if bus();
  huge_ball_controller dut (.clk(clk), .reset(reset), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  int m_state = 0, m_cnt = 0, m_x = 0, m_y = 0, m_vx = 0, m_vy = 0, m_pop = 0;
  task automatic check(string tag, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask
  task automatic pop_chk(string tag, int act);
    check(tag, act, exp_q.pop_front());
  endtask
  task automatic cycle(string tag);
    int tlx, tly, px, py, in;
    logic sof;
    tlx = m_x >>> 6;
    tly = m_y >>> 6;
    px  = int'(bus.pixelX);
    py  = int'(bus.pixelY);
    in  = (!reset && m_state != 0 && px >= tlx && px < tlx + 52 && py >= tly && py < tly + 52) ? 1 : 0;
    exp_q.push_back(in);
    exp_q.push_back(in ? px - tlx : 0);
    exp_q.push_back(in ? py - tly : 0);
`ifdef HUGE_BALL_FREEZE_EN
    sof = bus.startOfFrame && !bus.freeze;
`else
    sof = bus.startOfFrame;
`endif
    m_pop = 0;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_x = 0; m_y = 0; m_vx = 0; m_vy = 0;
    end else if (m_state == 0) begin
      if (bus.launch) begin
        m_state = 1;
        m_x = int'(bus.initX) * 64;
        m_y = 40 * 64;
        m_vx = bus.initDirLeft ? -128 : 128;
        m_vy = 0;
      end
    end else if (m_state == 1) begin
      if (bus.hit) begin
        m_state = 2; m_cnt = 0; m_pop = 1;
      end else if (sof) begin
        m_vy += 4;
        m_y += m_vy;
        m_x += m_vx;
        if (m_y > 388 * 64) begin m_y = 388 * 64; m_vy = -448; end
        else if (m_y < 0) begin m_y = 0; if (m_vy < 0) m_vy = -m_vy; end
        if (m_x > 588 * 64) begin m_x = 588 * 64; m_vx = -128; end
        else if (m_x < 0) begin m_x = 0; m_vx = 128; end
      end
    end else if (sof) begin
      m_cnt++;
      if (m_cnt == 16) m_state = 0;
    end
    exp_q.push_back(m_x >>> 6);
    exp_q.push_back(m_y >>> 6);
    exp_q.push_back(m_state != 0 ? 1 : 0);
    exp_q.push_back(m_pop);
    @(posedge clk);
    #1;
    pop_chk({tag, ".inside"}, int'(bus.InsideRectangle));
    pop_chk({tag, ".offX"}, int'(bus.offsetX));
    pop_chk({tag, ".offY"}, int'(bus.offsetY));
    pop_chk({tag, ".tlX"}, int'(bus.topLeftX));
    pop_chk({tag, ".tlY"}, int'(bus.topLeftY));
    pop_chk({tag, ".active"}, int'(bus.active));
    pop_chk({tag, ".popped"}, int'(bus.popped));
  endtask
  task automatic rand_pix();
    int bx, by;
    bx = m_x >>> 6;
    by = m_y >>> 6;
    bus.pixelX = 11'((bx - 4 + int'($urandom_range(59, 0))) & 2047);
    bus.pixelY = 11'((by - 4 + int'($urandom_range(59, 0))) & 2047);
  endtask
  task automatic frame(string tag);
    rand_pix();
    bus.startOfFrame = 1'b1;
    cycle(tag);
    bus.startOfFrame = 1'b0;
    rand_pix();
    cycle({tag, "_gap"});
  endtask
  task automatic pix(string tag, int x, int y);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
    cycle(tag);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    bus.startOfFrame = 1'b0; bus.pixelX = '0; bus.pixelY = '0; bus.launch = 1'b0;
    bus.initX = '0; bus.initDirLeft = 1'b0; bus.hit = 1'b0;
`ifdef HUGE_BALL_FREEZE_EN
    bus.freeze = 1'b0;
`endif
    #1;
    cycle("reset0");
    cycle("reset1");
    reset = 1'b0;
    check("reset.tlX", int'(bus.topLeftX), 0);
    cycle("idle");
    bus.launch = 1'b1; bus.initX = 11'd100; bus.initDirLeft = 1'b0; bus.hit = 1'b1;
    cycle("launch");
    bus.launch = 1'b0; bus.hit = 1'b0;
    check("launch.popped", int'(bus.popped), 0);
    pix("pix_in", 126, 50);
    check("pix_in.offX", int'(bus.offsetX), 26);
    pix("pix_right", 152, 50);
    check("pix_right.inside", int'(bus.InsideRectangle), 0);
    pix("pix_corner", 100, 40);
    check("pix_corner.inside", int'(bus.InsideRectangle), 1);
    pix("pix_left", 99, 40);
    pix("pix_bottom", 151, 91);
    pix("pix_below", 151, 92);
    for (int i = 0; i < 16; i++) frame("grav");
    check("grav16.tlX", int'(bus.topLeftX), 132);
    check("grav16.tlY", int'(bus.topLeftY), 48);
    for (int i = 0; i < 300 && m_y != 388 * 64; i++) frame("fall");
    check("floor.tlY", int'(bus.topLeftY), 388);
    frame("bounce");
    check("bounce.tlY", int'(bus.topLeftY), 381);
    bus.hit = 1'b1;
    cycle("hit");
    bus.hit = 1'b0;
    cycle("hit_after");
    bus.launch = 1'b1; bus.initX = 11'd5;
    cycle("pop_launch");
    bus.launch = 1'b0;
    for (int i = 0; i < 15; i++) frame("popping");
    check("pop15.active", int'(bus.active), 1);
    frame("pop16");
    check("pop16.active", int'(bus.active), 0);
    bus.launch = 1'b1; bus.initX = 11'd586; bus.initDirLeft = 1'b0;
    cycle("launch_r");
    bus.launch = 1'b0;
    frame("wall1");
    check("wall1.tlX", int'(bus.topLeftX), 588);
    frame("wall2");
    check("wall2.tlX", int'(bus.topLeftX), 588);
    frame("wall3");
    check("wall3.tlX", int'(bus.topLeftX), 586);
    bus.hit = 1'b1; bus.startOfFrame = 1'b1;
    cycle("hit_sof");
    bus.hit = 1'b0; bus.startOfFrame = 1'b0;
    check("hit_sof.tlX", int'(bus.topLeftX), 586);
    for (int i = 0; i < 16; i++) frame("pop2");
    bus.launch = 1'b1; bus.hit = 1'b1; bus.initX = 11'd300; bus.initDirLeft = 1'b1;
    cycle("launch_hit");
    bus.launch = 1'b0; bus.hit = 1'b0;
    bus.launch = 1'b1;
    frame("launch_moving");
    bus.launch = 1'b0;
`ifdef HUGE_BALL_FREEZE_EN
    for (int i = 0; i < 10; i++) frame("pre_freeze");
    bus.freeze = 1'b1;
    for (int i = 0; i < 5; i++) frame("freeze");
    bus.freeze = 1'b0;
    for (int i = 0; i < 3; i++) frame("unfreeze");
`endif
    for (int i = 0; i < 300; i++) frame("roam");
    check("roam.tlX", int'(bus.topLeftX), m_x >>> 6);
    reset = 1'b1;
    cycle("midreset");
    reset = 1'b0;
    cycle("post_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
